// File: rtl/adaptive_threshold_if.sv
// Sample, configuration and comparator result bundle for adaptive_threshold.
// master = ADC/config side, slave = the threshold detector.
interface adaptive_threshold_if #(
    parameter int ADC_WIDTH    = 12,
    parameter int PERIOD_WIDTH = 24
);
    logic [ADC_WIDTH-1:0]    adc_value;
    logic                    adc_value_change;
    logic                    mode_adaptive;
    logic [ADC_WIDTH-1:0]    fixed_threshold;
    logic [ADC_WIDTH-3:0]    hysteresis;
    logic                    pulse;
    logic                    pulse_rise;
    logic [ADC_WIDTH-1:0]    threshold;
    logic [ADC_WIDTH-1:0]    average;
    logic                    average_valid;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;

    modport master (
        output adc_value, adc_value_change, mode_adaptive, fixed_threshold, hysteresis,
        input  pulse, pulse_rise, threshold, average, average_valid, period, period_valid
    );

    modport slave (
        input  adc_value, adc_value_change, mode_adaptive, fixed_threshold, hysteresis,
        output pulse, pulse_rise, threshold, average, average_valid, period, period_valid
    );
endinterface

// File: rtl/adaptive_threshold.sv
// Hysteresis edge detector on a toggle-strobed ADC stream with fixed or running-average threshold.
// Optional period counter between rising edges is enabled by defining PERIOD_MEASURE_EN.
//
// state   | meaning
// ST_ARM  | first clock after reset: capture toggle level, no event
// ST_RUN  | armed: a toggle mismatch is a new-sample event
module adaptive_threshold #(
    parameter int ADC_WIDTH       = 12,
    parameter int AVG_DEPTH_LOG2  = 5,
    parameter int SAMPLE_INTERVAL = 8191,
    parameter int PERIOD_WIDTH    = 24
) (
    input  logic               clk,
    input  logic               rst,
    adaptive_threshold_if.slave bus
);
    localparam int W     = ADC_WIDTH;
    localparam int N     = 2 ** AVG_DEPTH_LOG2;
    localparam int SUM_W = W + AVG_DEPTH_LOG2;
    localparam int IDX_W = (AVG_DEPTH_LOG2 > 0) ? AVG_DEPTH_LOG2 : 1;
    localparam int CNT_W = $clog2(SAMPLE_INTERVAL);

    typedef enum logic {ST_ARM, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic             adc_event;
    logic             toggle_q;
    logic [W-1:0]     latched_q;
    logic             pulse_q, rise_q;
    logic [W-1:0]     threshold_q, average_q;
    logic             avg_valid_q;
    logic [W:0]       upper_sum, lower_diff;
    logic [W-1:0]     upper, lower;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     sample_buf [N];
    logic [SUM_W-1:0] sum_q, next_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ARM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        adc_event = 1'b0;
        case (state)
            ST_ARM: state_nxt = ST_RUN;
            ST_RUN: adc_event = (bus.adc_value_change != toggle_q);
            default: state_nxt = ST_ARM;
        endcase
    end

    // Band edges are widened by one bit so they saturate instead of wrapping
    always_comb begin
        upper_sum  = {1'b0, threshold_q} + {3'b000, bus.hysteresis};
        lower_diff = {1'b0, threshold_q} - {3'b000, bus.hysteresis};
        upper      = upper_sum[W]  ? '1 : upper_sum[W-1:0];
        lower      = lower_diff[W] ? '0 : lower_diff[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q  <= 1'b0;
            latched_q <= '0;
            pulse_q   <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (state == ST_ARM || adc_event)
                toggle_q <= bus.adc_value_change;
            if (adc_event) begin
                latched_q <= bus.adc_value;
                if (!pulse_q && bus.adc_value >= upper) begin
                    pulse_q <= 1'b1;
                    rise_q  <= 1'b1;
                end else if (pulse_q && bus.adc_value <= lower) begin
                    pulse_q <= 1'b0;
                end
            end
        end
    end

    assign tick     = (cnt_q == CNT_W'(SAMPLE_INTERVAL - 1));
    assign next_sum = sum_q + SUM_W'(latched_q) - SUM_W'(sample_buf[idx_q]);

    // latched_q is read before any same-cycle event updates it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            average_q   <= '0;
            avg_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) sample_buf[i] <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                sample_buf[idx_q] <= latched_q;
                sum_q             <= next_sum;
                average_q         <= next_sum[SUM_W-1:AVG_DEPTH_LOG2];
                idx_q             <= (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) avg_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) threshold_q <= {1'b1, {(W-1){1'b0}}};
        else     threshold_q <= (bus.mode_adaptive && avg_valid_q) ? average_q : bus.fixed_threshold;
    end

    assign bus.pulse         = pulse_q;
    assign bus.pulse_rise    = rise_q;
    assign bus.threshold     = threshold_q;
    assign bus.average       = average_q;
    assign bus.average_valid = avg_valid_q;

`ifdef PERIOD_MEASURE_EN
    logic [PERIOD_WIDTH-1:0] period_cnt_q, period_q;
    logic                    period_valid_q, rise_seen_q;

    // The first rise only starts the count; later rises report the elapsed clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q   <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            rise_seen_q    <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (rise_q) begin
                period_cnt_q <= PERIOD_WIDTH'(1);
                rise_seen_q  <= 1'b1;
                if (rise_seen_q) begin
                    period_q       <= period_cnt_q;
                    period_valid_q <= 1'b1;
                end
            end else if (period_cnt_q != '1) begin
                period_cnt_q <= period_cnt_q + 1'b1;
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
`else
    assign bus.period       = {PERIOD_WIDTH{1'b0}};
    assign bus.period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_adaptive_threshold.sv
// Scoreboard bench for adaptive_threshold (W=12, N=4, SAMPLE_INTERVAL=4).
// Edges are numbered E1, E2, ... from reset release; stimulus and expectations are scheduled on them.
module tb_adaptive_threshold;
    localparam int W  = 12;
    localparam int PW = 24;
    localparam int SIG_PULSE = 0, SIG_RISE = 1, SIG_THR = 2, SIG_AVG = 3,
                   SIG_VALID = 4, SIG_PERIOD = 5, SIG_PVALID = 6;
    localparam int K_TOG = 0, K_FIXED = 1, K_MODE = 2;

    typedef struct { int at_edge; int sig; int val; } exp_t;
    typedef struct { int at_edge; int kind; int val; } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t  sb[$];
    stim_t st[$];
    int   rst_exp [7] = '{0, 0, 2048, 0, 0, 0, 0};

    adaptive_threshold_if #(.ADC_WIDTH(W), .PERIOD_WIDTH(PW)) bus ();

    adaptive_threshold #(
        .ADC_WIDTH(W), .AVG_DEPTH_LOG2(2), .SAMPLE_INTERVAL(4), .PERIOD_WIDTH(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_PULSE:  return 32'(bus.pulse);
            SIG_RISE:   return 32'(bus.pulse_rise);
            SIG_THR:    return 32'(bus.threshold);
            SIG_AVG:    return 32'(bus.average);
            SIG_VALID:  return 32'(bus.average_valid);
            SIG_PERIOD: return 32'(bus.period);
            SIG_PVALID: return 32'(bus.period_valid);
            default:    return 'x;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_PULSE:  return "pulse";
            SIG_RISE:   return "pulse_rise";
            SIG_THR:    return "threshold";
            SIG_AVG:    return "average";
            SIG_VALID:  return "average_valid";
            SIG_PERIOD: return "period";
            SIG_PVALID: return "period_valid";
            default:    return "unknown";
        endcase
    endfunction

    function automatic void expect_at(input int k, input int sig, input int val);
        sb.push_back('{base + k, sig, val});
    endfunction

    function automatic void stim_at(input int k, input int kind, input int val);
        st.push_back('{base + k, kind, val});
    endfunction

    task automatic apply_due();
        for (int i = st.size() - 1; i >= 0; i--) begin
            if (st[i].at_edge == cyc) begin
                case (st[i].kind)
                    K_TOG: begin
                        bus.adc_value        = W'(st[i].val);
                        bus.adc_value_change = ~bus.adc_value_change;
                    end
                    K_FIXED: bus.fixed_threshold = W'(st[i].val);
                    default: bus.mode_adaptive   = st[i].val[0];
                endcase
                st.delete(i);
            end
        end
    endtask

    task automatic flush_pending(input string tname);
        if (st.size() != 0 || sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s schedule not drained got %0d pending exp 0", tname, st.size() + sb.size());
            st.delete();
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = cyc;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        bus.mode_adaptive    = 1'b0;
        bus.fixed_threshold  = '0;
        bus.hysteresis       = '0;
        bus.adc_value        = 12'd4095;
        bus.adc_value_change = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 7; s++) begin
            obs = observe(s);
            checks++;
            if (obs !== 32'(rst_exp[s])) begin
                errors++;
                $display("FAIL reset %s got %0d exp %0d", sig_name(s), obs, rst_exp[s]);
            end
        end
        rst = 1'b0;
        base = cyc;
        // toggle level differs from reset toggle_q, but the arming clock must not fire
        expect_at(1, SIG_PULSE, 0);
        expect_at(1, SIG_THR, 0);
        expect_at(2, SIG_PULSE, 0);
        stim_at(2, K_TOG, 0);
        expect_at(3, SIG_PULSE, 1);
        expect_at(3, SIG_RISE, 1);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL reset_arm %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("reset_arm");
    endtask

    task automatic test_fixed_hysteresis();
        logic [31:0] obs;
        bus.mode_adaptive   = 1'b0;
        bus.fixed_threshold = 12'd2048;
        bus.hysteresis      = 10'd256;
        do_reset();
        stim_at(1, K_TOG, 2200);
        stim_at(2, K_TOG, 2304);
        stim_at(4, K_TOG, 1900);
        stim_at(6, K_TOG, 1792);
        expect_at(2, SIG_PULSE, 0);
        expect_at(2, SIG_RISE, 0);
        expect_at(3, SIG_PULSE, 1);
        expect_at(3, SIG_RISE, 1);
        expect_at(3, SIG_THR, 2048);
        expect_at(4, SIG_RISE, 0);
        expect_at(5, SIG_PULSE, 1);
        expect_at(7, SIG_PULSE, 0);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL fixed_hyst %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("fixed_hyst");
    endtask

    task automatic test_saturation();
        logic [31:0] obs;
        bus.mode_adaptive   = 1'b0;
        bus.fixed_threshold = 12'd4000;
        bus.hysteresis      = 10'd200;
        do_reset();
        // upper clamps to 4095, so 4094 must not trip while 4095 does
        stim_at(1, K_TOG, 4094);
        stim_at(2, K_TOG, 4095);
        stim_at(4, K_FIXED, 100);
        stim_at(6, K_TOG, 1);
        stim_at(7, K_TOG, 0);
        expect_at(2, SIG_PULSE, 0);
        expect_at(3, SIG_PULSE, 1);
        expect_at(3, SIG_RISE, 1);
        expect_at(4, SIG_RISE, 0);
        expect_at(5, SIG_THR, 100);
        expect_at(7, SIG_PULSE, 1);
        expect_at(8, SIG_PULSE, 0);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL saturation %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("saturation");
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs;
        bus.mode_adaptive   = 1'b0;
        bus.fixed_threshold = 12'd2048;
        bus.hysteresis      = 10'd256;
        do_reset();
        stim_at(1, K_TOG, 2400);
        stim_at(2, K_TOG, 1700);
        stim_at(3, K_TOG, 2304);
        stim_at(4, K_TOG, 2000);
        stim_at(5, K_TOG, 1792);
        expect_at(2, SIG_PULSE, 1);
        expect_at(2, SIG_RISE, 1);
        expect_at(3, SIG_PULSE, 0);
        expect_at(3, SIG_RISE, 0);
        expect_at(4, SIG_PULSE, 1);
        expect_at(4, SIG_RISE, 1);
        expect_at(5, SIG_PULSE, 1);
        expect_at(5, SIG_RISE, 0);
        expect_at(6, SIG_PULSE, 0);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL back_to_back %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("back_to_back");
    endtask

    task automatic test_average();
        logic [31:0] obs;
        bus.mode_adaptive   = 1'b1;
        bus.fixed_threshold = 12'd3000;
        bus.hysteresis      = 10'd256;
        do_reset();
        // ticks land on E4, E8, E12, ...; slot order 0,1,2,3 repeating
        stim_at(1, K_TOG, 1000);
        expect_at(2, SIG_THR, 3000);
        expect_at(4, SIG_AVG, 250);
        expect_at(4, SIG_VALID, 0);
        expect_at(8, SIG_AVG, 500);
        expect_at(12, SIG_AVG, 750);
        expect_at(12, SIG_VALID, 0);
        expect_at(12, SIG_THR, 3000);
        expect_at(16, SIG_AVG, 1000);
        expect_at(16, SIG_VALID, 1);
        expect_at(16, SIG_THR, 3000);
        expect_at(17, SIG_THR, 1000);
        stim_at(29, K_TOG, 1003);
        expect_at(32, SIG_AVG, 1000);
        stim_at(33, K_TOG, 0);
        expect_at(36, SIG_AVG, 750);
        expect_at(37, SIG_THR, 750);
        stim_at(37, K_MODE, 0);
        expect_at(38, SIG_THR, 3000);
        stim_at(38, K_MODE, 1);
        expect_at(39, SIG_THR, 750);
        expect_at(40, SIG_VALID, 1);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL average %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("average");
    endtask

    task automatic test_collision_reset();
        logic [31:0] obs;
        bus.mode_adaptive   = 1'b1;
        bus.fixed_threshold = 12'd3000;
        bus.hysteresis      = 10'd256;
        do_reset();
        // event 800 coincides with the E4 tick, which must still store 500
        stim_at(1, K_TOG, 500);
        stim_at(3, K_TOG, 800);
        expect_at(4, SIG_AVG, 125);
        expect_at(8, SIG_AVG, 325);
        stim_at(8, K_TOG, 3500);
        expect_at(9, SIG_PULSE, 1);
        expect_at(9, SIG_RISE, 1);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL collision %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("collision");
        rst = 1'b1;
        #1;
        for (int s = 0; s < 7; s++) begin
            obs = observe(s);
            checks++;
            if (obs !== 32'(rst_exp[s])) begin
                errors++;
                $display("FAIL midrun_reset %s got %0d exp %0d", sig_name(s), obs, rst_exp[s]);
            end
        end
        do_reset();
        stim_at(1, K_TOG, 400);
        expect_at(4, SIG_AVG, 100);
        expect_at(4, SIG_VALID, 0);
        expect_at(8, SIG_VALID, 0);
        expect_at(12, SIG_AVG, 300);
        expect_at(12, SIG_VALID, 0);
        expect_at(16, SIG_AVG, 400);
        expect_at(16, SIG_VALID, 1);
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL after_reset %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("after_reset");
    endtask

    task automatic test_period();
        logic [31:0] obs;
        bus.mode_adaptive   = 1'b0;
        bus.fixed_threshold = 12'd2048;
        bus.hysteresis      = 10'd256;
        do_reset();
        // rises on E2, E102, E152
        stim_at(1, K_TOG, 2400);
        stim_at(10, K_TOG, 1000);
        stim_at(101, K_TOG, 2400);
        stim_at(120, K_TOG, 1000);
        stim_at(151, K_TOG, 2400);
        expect_at(2, SIG_RISE, 1);
        expect_at(3, SIG_PVALID, 0);
        expect_at(102, SIG_RISE, 1);
`ifdef PERIOD_MEASURE_EN
        expect_at(103, SIG_PERIOD, 100);
        expect_at(103, SIG_PVALID, 1);
        expect_at(104, SIG_PVALID, 0);
        expect_at(104, SIG_PERIOD, 100);
        expect_at(153, SIG_PERIOD, 50);
        expect_at(153, SIG_PVALID, 1);
`else
        expect_at(103, SIG_PERIOD, 0);
        expect_at(103, SIG_PVALID, 0);
        expect_at(153, SIG_PERIOD, 0);
        expect_at(153, SIG_PVALID, 0);
`endif
        for (int g = 0; g < 400 && (st.size() > 0 || sb.size() > 0); g++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_edge == cyc) begin
                    obs = observe(sb[i].sig);
                    checks++;
                    if (obs !== 32'(sb[i].val)) begin
                        errors++;
                        $display("FAIL period %s E%0d got %0d exp %0d", sig_name(sb[i].sig), cyc - base, obs, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
            apply_due();
        end
        flush_pending("period");
    endtask

    initial begin
        bus.adc_value        = '0;
        bus.adc_value_change = 1'b0;
        bus.mode_adaptive    = 1'b0;
        bus.fixed_threshold  = 12'd2048;
        bus.hysteresis       = '0;
        test_reset();
        test_fixed_hysteresis();
        test_saturation();
        test_back_to_back();
        test_average();
        test_collision_reset();
        test_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
